// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants for the sprite line scheduler and its slot buffer.
//   - Sprite table geometry (entry count, entry width, posY field position).
//   - Slot count for the tile drawer bank and the sprite height in lines.
//   - VGA line counter width and the first VGA line of the game area.
//   - Scan FSM state encodings.
package sprite_line_scheduler_pkg;

  localparam int BYTE            = 8;
  localparam int VGA_POSXY_BIT   = 10;
  localparam int GAME_START_POSY = 0;

  localparam int SPRITE_NUM_MAX  = 32;
  localparam int SPRITE_SLOT_NUM = 8;
  localparam int SPRITE_TILE_H   = 8;

  // posY field inside a 32-bit spriteViewRam entry
  localparam int SPRITE_POSY_MSB = 23;
  localparam int SPRITE_POSY_LSB = 16;

  // Scan FSM states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/sprite_slot_buffer.sv
// Build/active slot list pair.
//   The build list collects sprite indices in arrival order while a scan runs;
//   swap publishes it to the active list and empties it in the same clock.
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   swap         publish build list to active list and clear build list
//   push         a sprite hit is presented this clock
//   push_index   sprite index of that hit
//   full         build list already holds SLOT_NUM sprites
//   slot_index   active list, slot k = [k*IDXW +: IDXW]
//   slot_valid   active slot k holds a sprite
//   overflow     active line had more hits than slots
module sprite_slot_buffer
  import sprite_line_scheduler_pkg::*;
#(
  parameter int SLOT_NUM = SPRITE_SLOT_NUM,
  parameter int IDXW     = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     swap,
  input  logic                     push,
  input  logic [IDXW-1:0]          push_index,
  output logic                     full,
  output logic [SLOT_NUM*IDXW-1:0] slot_index,
  output logic [SLOT_NUM-1:0]      slot_valid,
  output logic                     overflow
);

  localparam int CNTW = $clog2(SLOT_NUM + 1);

  logic [IDXW-1:0]     build_index [SLOT_NUM];
  logic [CNTW-1:0]     build_count;
  logic                build_overflow;
  logic [SLOT_NUM-1:0] build_valid;

  // Slots fill from 0 upward, so the filled slots are exactly those below the count.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    build_valid = '0;
    for (int k = 0; k < SLOT_NUM; k++) begin
      if (k < int'(build_count)) build_valid[k] = 1'b1;
    end
  end

  assign full = (int'(build_count) == SLOT_NUM);

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      // NOTE: the slot arrays are a handful of flops, not RAM, so they reset like any other state.
      for (int k = 0; k < SLOT_NUM; k++) build_index[k] <= '0;
      build_count    <= '0;
      build_overflow <= 1'b0;
      slot_index     <= '0;
      slot_valid     <= '0;
      overflow       <= 1'b0;
    end else if (swap) begin
      for (int k = 0; k < SLOT_NUM; k++) begin
        slot_index[k*IDXW +: IDXW] <= build_index[k];
        build_index[k]             <= '0;
      end
      slot_valid     <= build_valid;
      overflow       <= build_overflow;
      build_count    <= '0;
      build_overflow <= 1'b0;
    end else if (push) begin
      if (full) begin
        build_overflow <= 1'b1;
      end else begin
        // Only the next free slot is written, so two hits never share a slot.
        for (int k = 0; k < SLOT_NUM; k++) begin
          if (k == int'(build_count)) build_index[k] <= push_index;
        end
        build_count <= build_count + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator and scheduler for the tile drawer bank.
//   On each line_start it publishes the slot list built during the previous line,
//   then scans every spriteViewRam entry for the line that follows and records up
//   to SLOT_NUM visible sprite indices, lowest entry index in slot 0.
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   line_start   one-clock pulse at the start of each VGA line
//   vga_pos_y    VGA line being displayed, sampled on line_start
//   ram_index    spriteViewRam read address
//   ram_data     entry data, valid one clock after ram_index is captured; posY = [23:16]
//   slot_index   active slot indices, slot k = [k*IDXW +: IDXW]
//   slot_valid   active slot k holds a sprite
//   overflow     more than SLOT_NUM sprites hit the active line
//   scan_late    active list is partial because the scan was cut short
//   busy         scan in progress
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int SPRITE_NUM  = SPRITE_NUM_MAX,
  parameter int SLOT_NUM    = SPRITE_SLOT_NUM,
  parameter int TILE_H      = SPRITE_TILE_H,
  parameter int START_POSY  = GAME_START_POSY,
  parameter int IDXW        = $clog2(SPRITE_NUM)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     line_start,
  input  logic [VGA_POSXY_BIT-1:0] vga_pos_y,
  output logic [IDXW-1:0]          ram_index,
  input  logic [4*BYTE-1:0]        ram_data,
  output logic [SLOT_NUM*IDXW-1:0] slot_index,
  output logic [SLOT_NUM-1:0]      slot_valid,
  output logic                     overflow,
  output logic                     scan_late,
  output logic                     busy
);

  localparam int              YW         = VGA_POSXY_BIT + 1;
  localparam logic [IDXW-1:0] LAST_INDEX = IDXW'(SPRITE_NUM - 1);
  localparam logic [YW-1:0]   START_Y    = YW'(START_POSY);

  logic [1:0]      state;
  logic [8:0]      tgt_y;
  logic [8:0]      tgt_next;
  logic [YW-1:0]   line_y;
  logic            pend;
  logic [IDXW-1:0] eval_index;
  logic [7:0]      pos_y;
  logic            hit;
  logic            push;
  logic            full;
  logic            stop;
  logic            unused_ram_bits;

  // Game line to be drawn next. Anything at or above 256, or below the game
  // area (wraps to a large value), collapses onto bit 8 = "outside, no hits".
  assign line_y   = {1'b0, vga_pos_y} + YW'(1) - START_Y;
  assign tgt_next = {|line_y[YW-1:8], line_y[7:0]};

  assign pos_y = ram_data[SPRITE_POSY_MSB:SPRITE_POSY_LSB];
  // The remaining entry fields are consumed by the tile drawers, not here.
  assign unused_ram_bits = ^{ram_data[4*BYTE-1:SPRITE_POSY_MSB+1], ram_data[SPRITE_POSY_LSB-1:0]};

  // 9-bit compare: a sprite at posY=254 spans 254..261 and must not wrap onto lines 0..5.
  assign hit  = pend && !tgt_y[8]
             && ({1'b0, pos_y} <= tgt_y)
             && (tgt_y < ({1'b0, pos_y} + 9'(TILE_H)));
  assign push = hit && !line_start;
  assign stop = push && full;

  assign busy = (state == SCAN) || (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      ram_index  <= '0;
      tgt_y      <= '0;
      pend       <= 1'b0;
      eval_index <= '0;
      scan_late  <= 1'b0;
    end else if (line_start) begin
      // A scan still running here never reached the end of the table.
      scan_late <= busy;
      state     <= SCAN;
      ram_index <= '0;
      tgt_y     <= tgt_next;
      pend      <= 1'b0;
    end else begin
      // The RAM captures ram_index at this edge; its data is judged on the next one.
      pend       <= (state == SCAN);
      eval_index <= ram_index;
      case (state)
        SCAN: begin
          if (ram_index == LAST_INDEX) state <= DRAIN;
          else                         ram_index <= ram_index + IDXW'(1);
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
      // A hit with no free slot settles the overflow flag; nothing later can change the list.
      if (stop) begin
        state <= IDLE;
        pend  <= 1'b0;
      end
    end
  end

  sprite_slot_buffer #(
    .SLOT_NUM (SLOT_NUM),
    .IDXW     (IDXW)
  ) u_slot_buffer (
    .clk        (clk),
    .rstn       (rstn),
    .swap       (line_start),
    .push       (push),
    .push_index (eval_index),
    .full       (full),
    .slot_index (slot_index),
    .slot_valid (slot_valid),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler.
// A list-level model predicts, for each line, which entries a full or truncated
// scan reaches and what list it publishes; a compare process checks every cycle.
module tb_sprite_line_scheduler;
  import sprite_line_scheduler_pkg::*;

  localparam int N    = SPRITE_NUM_MAX;
  localparam int S    = SPRITE_SLOT_NUM;
  localparam int TH   = SPRITE_TILE_H;
  localparam int IDXW = $clog2(N);

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                line_start = 1'b0;
  logic [9:0]          vga_pos_y = '0;
  logic [IDXW-1:0]     ram_index;
  logic [31:0]         ram_data;
  logic [S*IDXW-1:0]   slot_index;
  logic [S-1:0]        slot_valid;
  logic                overflow, scan_late, busy;

  always #5 clk = ~clk;

  sprite_line_scheduler dut (
    .clk        (clk),
    .rstn       (rstn),
    .line_start (line_start),
    .vga_pos_y  (vga_pos_y),
    .ram_index  (ram_index),
    .ram_data   (ram_data),
    .slot_index (slot_index),
    .slot_valid (slot_valid),
    .overflow   (overflow),
    .scan_late  (scan_late),
    .busy       (busy)
  );

  // spriteViewRam second read port: synchronous read, posY in [23:16], filler elsewhere.
  logic [7:0] mem [N];
  always @(posedge clk) ram_data <= {8'hA5, mem[ram_index], 8'h3C, 8'h5A};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Entry k of a scan is decided k+2 clocks after its line_start; a full scan
  // ends N+1 clocks after it, or two clocks after the first hit with no free slot.
  int              cyc = 0;
  int              start_cyc = 0;
  bit              has_scan = 0;
  bit              snap_hit [N];
  int              snap_end = 0;
  bit              model_ready = 0;
  logic [S*IDXW-1:0] e_idx = '0;
  logic [S-1:0]      e_val = '0;
  logic              e_ovf = 1'b0, e_late = 1'b0, e_busy = 1'b0;
  logic [IDXW-1:0]   e_ridx = '0;

  initial begin
    int e, cnt, t, p;
    forever begin
      @(posedge clk);
      cyc++;
      model_ready = 1'b1;
      if (!rstn) begin
        has_scan = 0;
        e_idx = '0; e_val = '0; e_ovf = 1'b0; e_late = 1'b0; e_busy = 1'b0; e_ridx = '0;
      end else if (line_start) begin
        // publish what the previous scan reached
        e = cyc - start_cyc;
        e_idx = '0; e_val = '0; e_ovf = 1'b0; e_late = 1'b0;
        if (has_scan) begin
          cnt = 0;
          for (int k = 0; k < N; k++) begin
            if (k + 2 >= e) begin e_late = 1'b1; break; end
            if (snap_hit[k]) begin
              if (cnt == S) begin e_ovf = 1'b1; break; end
              e_idx[cnt*IDXW +: IDXW] = IDXW'(k);
              e_val[cnt] = 1'b1;
              cnt++;
            end
          end
        end
        // start the next scan
        t = int'(vga_pos_y) + 1 - GAME_START_POSY;
        for (int k = 0; k < N; k++) begin
          p = int'(mem[k]);
          snap_hit[k] = (t >= 0) && (t < 256) && (t >= p) && (t < p + TH);
        end
        snap_end = N + 1;
        cnt = 0;
        for (int k = 0; k < N; k++) begin
          if (snap_hit[k]) begin
            if (cnt == S) begin snap_end = k + 2; break; end
            cnt++;
          end
        end
        start_cyc = cyc;
        has_scan  = 1;
        e_busy    = 1'b1;
        e_ridx    = '0;
      end else if (has_scan) begin
        e = cyc - start_cyc;
        e_busy = (e < snap_end);
        if (e > snap_end) e = snap_end;
        e_ridx = IDXW'((e > N - 1) ? N - 1 : e);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("slot_index", 64'(slot_index), 64'(e_idx));
      check("slot_valid", 64'(slot_valid), 64'(e_val));
      check("overflow",   64'(overflow),   64'(e_ovf));
      check("scan_late",  64'(scan_late),  64'(e_late));
      check("busy",       64'(busy),       64'(e_busy));
      check("ram_index",  64'(ram_index),  64'(e_ridx));
    end
  end

  // ---------------- stimulus ----------------
  // pulse: line_start for one clock; returns on the negedge after the publishing edge.
  task automatic pulse(input int vy);
    @(negedge clk);
    line_start = 1'b1;
    vga_pos_y  = 10'(vy);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int k = 0; k < N; k++) mem[k] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_mem(8'd200);
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_valid", 64'(slot_valid), 64'd0);

    // single sprite: entry 5 covers game lines 10..17
    mem[5] = 8'd10;
    pulse(9);   idle(40);
    pulse(12);  check("single_t10_valid", 64'(slot_valid), 64'h01);
                check("single_t10_index", 64'(slot_index[IDXW-1:0]), 64'd5);
    idle(40);
    pulse(16);  check("single_t13_valid", 64'(slot_valid), 64'h01);
    idle(40);
    pulse(17);  check("single_t17_valid", 64'(slot_valid), 64'h01);
    idle(40);
    pulse(18);  check("single_t18_valid", 64'(slot_valid), 64'h00);
    idle(40);
    pulse(0);   check("single_t19_valid", 64'(slot_valid), 64'h00);
    // latency: busy through N+1 clocks, ram_index parked at the last entry
    idle(N);
    check("lat_busy_hi", 64'(busy), 64'd1);
    check("lat_ridx",    64'(ram_index), 64'(N - 1));
    idle(1);
    check("lat_busy_lo", 64'(busy), 64'd0);
    idle(10);

    // reset in the middle of a scan while the active list is populated
    pulse(9);   idle(40);
    pulse(9);   check("pre_rst_valid", 64'(slot_valid), 64'h01);
    idle(10);
    rstn = 1'b0;
    idle(3);
    check("mid_rst_valid", 64'(slot_valid), 64'd0);
    check("mid_rst_busy",  64'(busy), 64'd0);
    check("mid_rst_ridx",  64'(ram_index), 64'd0);
    rstn = 1'b1;
    pulse(12);  check("post_rst_valid", 64'(slot_valid), 64'd0);
                check("post_rst_late",  64'(scan_late), 64'd0);
    idle(40);
    pulse(100); check("post_rst_scan", 64'(slot_valid), 64'h01);
    idle(40);

    // ordering / overflow: entries 2,4..20 all at posY 0
    mem[5] = 8'd200;
    for (int k = 2; k <= 20; k += 2) mem[k] = 8'd0;
    pulse(0);   idle(40);
    pulse(100); check("ovf_flag",  64'(overflow), 64'd1);
                check("ovf_valid", 64'(slot_valid), 64'hFF);
                check("ovf_index", 64'(slot_index),
                      64'({5'd16, 5'd14, 5'd12, 5'd10, 5'd8, 5'd6, 5'd4, 5'd2}));
    idle(40);
    mem[18] = 8'd200;
    mem[20] = 8'd200;
    pulse(0);   idle(40);
    pulse(100); check("eight_flag",  64'(overflow), 64'd0);
                check("eight_valid", 64'(slot_valid), 64'hFF);
    idle(40);

    // edge wrap: entry 0 spans 254..261 in 9-bit space
    fill_mem(8'd200);
    mem[0] = 8'd254;
    pulse(2);   idle(40);
    pulse(254); check("wrap_t3_valid", 64'(slot_valid), 64'h00);
    idle(40);
    pulse(255); check("wrap_t255_valid", 64'(slot_valid), 64'h01);
                check("wrap_t255_index", 64'(slot_index[IDXW-1:0]), 64'd0);
    idle(40);
    pulse(100); check("outside_t256_valid", 64'(slot_valid), 64'h00);
    idle(40);

    // late scan: second line_start N/2 clocks after the first
    mem[20] = 8'd250;
    pulse(254); idle(N/2 - 1);
    pulse(254); check("late_flag",  64'(scan_late), 64'd1);
                check("late_valid", 64'(slot_valid), 64'h01);
    idle(40);
    pulse(100); check("full_flag",  64'(scan_late), 64'd0);
                check("full_valid", 64'(slot_valid), 64'h03);
                check("full_index", 64'(slot_index[2*IDXW-1:0]), 64'({5'd20, 5'd0}));
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
